uart_imem_loader: RTL

//  Boot-time program loader, directly downstream of the UART receiver.

---
 rtl/loader_pkg.sv | 15 +
 rtl/uart_imem_loader_if.sv | 21 ++
 rtl/uart_imem_loader_packer.sv | 42 ++++
 rtl/uart_imem_loader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_e;

    localparam logic [31:0] END_MARKER_DEF = 32'hFFFF_FFFF;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/uart_imem_loader_if.sv
// UART byte stream in, instruction-memory write port out.
interface uart_imem_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_break;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_valid, rx_data, rx_break,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data, rx_break,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/uart_imem_loader_packer.sv
// Little-endian byte-to-word packer; byte_idx is exported only when
// LOADER_TIMEOUT_EN is defined (the timeout is its only consumer).
module uart_word_packer
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  accept,
    input  logic                  clear,
    input  logic [7:0]            data,
`ifdef LOADER_TIMEOUT_EN
    output logic [BYTE_IDX_W-1:0] byte_idx,
`endif
    output logic                  word_ready_c,
    output logic [31:0]           word_c
);

    logic [BYTE_IDX_W-1:0] idx_q;
    logic [31:0]           shreg_q;

    // New byte enters at the top, so after four shifts the first byte is the LSB.
    assign word_c       = {data, shreg_q[31:8]};
    assign word_ready_c = accept && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

`ifdef LOADER_TIMEOUT_EN
    assign byte_idx = idx_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else if (clear) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else if (accept) begin
            idx_q   <= idx_q + BYTE_IDX_W'(1);
            shreg_q <= word_c;
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes into words and writes them to IMEM from address 0.
// Optional idle timeout for partial words: define LOADER_TIMEOUT_EN.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8,
    parameter logic [31:0] END_MARKER = END_MARKER_DEF
`ifdef LOADER_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 2_000_000
`endif
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load_en,
    uart_imem_loader_if.slave      bus,
    output logic [ADDR_W:0]        word_count,
    output logic                   write_done,
    output logic                   overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] COLLECT = ST_COLLECT;
    localparam logic [1:0] WRITE   = ST_WRITE;
    localparam logic [1:0] DONE    = ST_DONE;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic        accept_c;
    logic        clear_c;
    logic        timeout_c;
    logic        word_ready_c;
    logic [31:0] word_c;

    assign accept_c = bus.rx_valid && load_en && !bus.rx_break && (state_q != DONE);
    assign clear_c  = bus.rx_break || timeout_c;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [TO_W-1:0]       to_cnt_q;

    assign timeout_c = (to_cnt_q == TO_W'(TIMEOUT_CYC));

    // Counts idle cycles only while a partial word is pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else if (accept_c || timeout_c || (byte_idx == '0)) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    uart_word_packer u_packer (
        .clk          (clk),
        .resetn       (resetn),
        .accept       (accept_c),
        .clear        (clear_c),
        .data         (bus.rx_data),
`ifdef LOADER_TIMEOUT_EN
        .byte_idx     (byte_idx),
`endif
        .word_ready_c (word_ready_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Word disposition is decided in the accept cycle so the strobe lands one cycle later.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ovf_d   = ovf_q;

        if (we_q) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (accept_c) state_d = COLLECT;
            end
            COLLECT: begin
                if (word_ready_c) begin
                    if (word_c == END_MARKER) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (cnt_q == CNT_W'(IMEM_DEPTH)) begin
                        done_d  = 1'b1;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = word_c;
                        state_d = WRITE;
                    end
                end
            end
            WRITE:   state_d = COLLECT;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign word_count     = cnt_q;
    assign write_done     = done_q;
    assign overflow       = ovf_q;

endmodule
